// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks the EXE/MEM destinations and one long-latency unit,
// and raises the decode stall for load-use, long-dependency and structural hazards.
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE [4:0]
`endif

module hazard_scoreboard #(
  parameter int unsigned LONG_LAT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic `GPR_ADDR_SPACE id_rs1_addr,
  input  logic `GPR_ADDR_SPACE id_rs2_addr,
  input  logic                 id_rs1_re,
  input  logic                 id_rs2_re,
  input  logic `GPR_ADDR_SPACE id_rd_addr,
  input  logic                 id_rd_we,
  input  logic                 id_mem_re,
  input  logic                 id_long,
  input  logic                 ext_stall,
  input  logic                 flush,
  input  logic                 long_wb_ack,
  output logic                 stall,
  output logic                 long_start,
  output logic                 long_busy,
  output logic `GPR_ADDR_SPACE long_rd_addr,
  output logic                 long_wb_req
);

  typedef logic `GPR_ADDR_SPACE gpr_t;
  localparam gpr_t GPR_ZERO = '0;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LONG_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} long_state_e;

  typedef struct packed {
    logic valid;
    gpr_t rd;
    logic rd_we;
    logic is_load;
    logic is_long;
  } exe_slot_t;

  typedef struct packed {
    logic valid;
    gpr_t rd;
    logic rd_we;
    logic is_load;
  } mem_slot_t;

  exe_slot_t        exe_q, exe_d;
  mem_slot_t        mem_q, mem_d;
  long_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  gpr_t             long_rd_q;
  logic             busy_q, wb_req_q;
  logic             load_use_s, long_dep_s, struct_s, stall_s, issue_s, launch_s;
  logic             unused_mem_s;

  function automatic logic src_hit(input logic vld, input logic re, input gpr_t a, input gpr_t tgt);
    return vld & re & (a != GPR_ZERO) & (a == tgt);
  endfunction

  // Only a load in EXE cannot be forwarded; the long unit blocks readers, WAW writers and a second long op.
  assign load_use_s = exe_q.valid & exe_q.rd_we & exe_q.is_load &
                      (src_hit(id_valid, id_rs1_re, id_rs1_addr, exe_q.rd) |
                       src_hit(id_valid, id_rs2_re, id_rs2_addr, exe_q.rd));
  assign long_dep_s = busy_q &
                      (src_hit(id_valid, id_rs1_re, id_rs1_addr, long_rd_q) |
                       src_hit(id_valid, id_rs2_re, id_rs2_addr, long_rd_q) |
                       (id_valid & id_rd_we & (id_rd_addr == long_rd_q)));
  assign struct_s   = id_valid & id_long & (busy_q | (exe_q.valid & exe_q.is_long));
  assign stall_s    = ~flush & (load_use_s | long_dep_s | struct_s);
  assign issue_s    = id_valid & ~stall_s & ~ext_stall & ~flush;
  assign launch_s   = exe_q.valid & exe_q.is_long & ~ext_stall & ~flush & (state_q == IDLE);

  assign stall        = stall_s;
  assign long_start   = launch_s;
  assign long_busy    = busy_q;
  assign long_wb_req  = wb_req_q;
  assign long_rd_addr = long_rd_q;
  assign unused_mem_s = ^mem_q;

  // Next-state of the EXE and MEM tracking slots.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    if (!ext_stall) begin
      mem_d.valid   = exe_q.valid & ~exe_q.is_long & ~flush;
      mem_d.rd      = exe_q.rd;
      mem_d.rd_we   = exe_q.rd_we;
      mem_d.is_load = exe_q.is_load;
      if (issue_s) begin
        exe_d = '{valid: 1'b1, rd: id_rd_addr, rd_we: id_rd_we, is_load: id_mem_re, is_long: id_long};
      end else begin
        exe_d.valid = 1'b0;
      end
    end else if (flush) begin
      exe_d.valid = 1'b0;
    end else begin
      exe_d = exe_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q <= '0;
      mem_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
    end
  end

  // Long-unit FSM; the counter ignores ext_stall so the divider keeps running under a freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      long_rd_q <= '0;
      busy_q    <= 1'b0;
      wb_req_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_s) begin
            state_q   <= RUN;
            cnt_q     <= LAT_M1;
            long_rd_q <= exe_q.rd;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q  <= DONE;
            wb_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (long_wb_ack) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            wb_req_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          wb_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE [4:0]
`endif

module tb_hazard_scoreboard;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs1_re, id_rs2_re, id_rd_we, id_mem_re, id_long;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       ext_stall, flush, long_wb_ack;
  logic       stall, long_start, long_busy, long_wb_req;
  logic [4:0] long_rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: EXE slot contents, remaining execution cycles, result-ready flag.
  bit         m_exe_v, m_exe_we, m_exe_ld, m_exe_lg;
  logic [4:0] m_exe_rd, m_rd;
  int         m_left;
  bit         m_ready;

  hazard_scoreboard #(.LONG_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_mem_re(id_mem_re), .id_long(id_long),
    .ext_stall(ext_stall), .flush(flush), .long_wb_ack(long_wb_ack),
    .stall(stall), .long_start(long_start), .long_busy(long_busy),
    .long_rd_addr(long_rd_addr), .long_wb_req(long_wb_req)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic re1, input logic [4:0] rs2,
                        input logic re2, input logic [4:0] rd, input logic we, input logic ld, input logic lg);
    id_valid = v; id_rs1_addr = rs1; id_rs1_re = re1; id_rs2_addr = rs2; id_rs2_re = re2;
    id_rd_addr = rd; id_rd_we = we; id_mem_re = ld; id_long = lg;
  endtask

  task automatic idle_inputs();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    ext_stall = 1'b0; flush = 1'b0; long_wb_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({stall, long_start, long_busy, long_wb_req} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_outputs: got %b expected 0000", {stall, long_start, long_busy, long_wb_req}); end
    n_checks++; if (long_rd_addr !== 5'd0) begin
      n_errors++; $display("FAIL reset_long_rd: got %0d expected 0", long_rd_addr); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (long_start !== 1'b0) begin
      n_errors++; $display("FAIL release_no_start: got %b expected 0", long_start); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (long_start !== 1'b1) begin
      n_errors++; $display("FAIL release_first_edge: got %b expected 1", long_start); end
    tick();
  endtask

  task automatic test_load_use();
    int cnt = 0;
    bit done = 0;
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin
      n_errors++; $display("FAIL lu_load_issue: got %b expected 0", stall); end
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (stall === 1'b1) cnt++; else done = 1;
      tick();
      if (done) break;
    end
    n_checks++; if (!done || cnt != 1) begin
      n_errors++; $display("FAIL lu_stall_cycles: got %0d (released=%0d) expected 1", cnt, done); end
    idle_inputs();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    #1; tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin
      n_errors++; $display("FAIL lu_x0: got %b expected 0", stall); end
    tick(); idle_inputs();
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1; tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin
      n_errors++; $display("FAIL fwd_exe: got %b expected 0", stall); end
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin
      n_errors++; $display("FAIL fwd_mem: got %b expected 0", stall); end
    tick(); idle_inputs();
  endtask

  task automatic test_long_dep();
    int stall_c = 0, run_c = 0, done_c = 0, starts = 0, rd_bad = 0;
    bit released = 0;
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    #1; tick();
    idle_inputs();
    #1;
    n_checks++; if (long_start !== 1'b1) begin
      n_errors++; $display("FAIL div_start: got %b expected 1", long_start); end
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      long_wb_ack = 1'b0;
      #1;
      if (long_busy !== 1'b1) begin released = 1; break; end
      if (stall === 1'b1) stall_c++;
      if (long_start === 1'b1) starts++;
      if (long_rd_addr !== 5'd7) rd_bad++;
      if (long_wb_req === 1'b1) begin done_c++; long_wb_ack = (done_c == 4); end
      else run_c++;
      tick();
    end
    n_checks++; if (!released || stall !== 1'b0) begin
      n_errors++; $display("FAIL div_release: got released=%0d stall=%b expected 1/0", released, stall); end
    n_checks++; if (stall_c != 8) begin
      n_errors++; $display("FAIL div_stall_cycles: got %0d expected 8", stall_c); end
    n_checks++; if (run_c != LAT) begin
      n_errors++; $display("FAIL div_run_cycles: got %0d expected %0d", run_c, LAT); end
    n_checks++; if (starts != 0 || rd_bad != 0) begin
      n_errors++; $display("FAIL div_extra: got starts=%0d rd_bad=%0d expected 0/0", starts, rd_bad); end
    tick(); idle_inputs(); long_wb_ack = 1'b0;
  endtask

  task automatic test_struct_flush();
    int cnt = 0;
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
    #1; tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++; if ({long_start, stall} !== 2'b11) begin
      n_errors++; $display("FAIL struct_exe: got start,stall=%b expected 11", {long_start, stall}); end
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall !== 1'b1) break;
      cnt++;
      long_wb_ack = long_wb_req;
      tick();
      long_wb_ack = 1'b0;
    end
    n_checks++; if (cnt != LAT + 1 || long_busy !== 1'b0) begin
      n_errors++; $display("FAIL struct_stall: got cycles=%0d busy=%b expected %0d/0", cnt, long_busy, LAT + 1); end
    tick();
    idle_inputs(); flush = 1'b1;
    #1;
    n_checks++; if (long_start !== 1'b0) begin
      n_errors++; $display("FAIL flush_no_start: got %b expected 0", long_start); end
    tick(); flush = 1'b0;
    #1;
    n_checks++; if ({long_busy, long_start} !== 2'b00) begin
      n_errors++; $display("FAIL flush_idle: got busy,start=%b expected 00", {long_busy, long_start}); end
    tick();
  endtask

  task automatic test_ext_stall();
    int held = 0;
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1);
    #1; tick();
    idle_inputs(); #1; tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0) begin
      n_errors++; $display("FAIL xs_load_issue: got %b expected 0", stall); end
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall === 1'b1 && long_wb_req === 1'b0) held++;
      tick();
    end
    n_checks++; if (held != 3) begin
      n_errors++; $display("FAIL xs_frozen: got %0d stalled cycles expected 3", held); end
    ext_stall = 1'b0;
    #1;
    n_checks++; if ({long_wb_req, stall} !== 2'b11) begin
      n_errors++; $display("FAIL xs_counting: got wb_req,stall=%b expected 11", {long_wb_req, stall}); end
    long_wb_ack = 1'b1;
    tick(); long_wb_ack = 1'b0;
    #1;
    n_checks++; if ({long_busy, stall} !== 2'b00) begin
      n_errors++; $display("FAIL xs_release: got busy,stall=%b expected 00", {long_busy, stall}); end
    tick(); idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    #1; tick();
    idle_inputs(); #1; tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if ({long_busy, stall} !== 2'b11) begin
      n_errors++; $display("FAIL rst_run_pre: got busy,stall=%b expected 11", {long_busy, stall}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({long_busy, long_wb_req, stall, long_start} !== 4'b0000 || long_rd_addr !== 5'd0) begin
      n_errors++; $display("FAIL rst_run_now: got %b rd=%0d expected 0000 rd=0",
                           {long_busy, long_wb_req, stall, long_start}, long_rd_addr); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin
      n_errors++; $display("FAIL rst_run_dep: got %b expected 0", stall); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if ({long_busy, long_start} !== 2'b00) begin
      n_errors++; $display("FAIL rst_run_after: got busy,start=%b expected 00", {long_busy, long_start}); end
    tick();
  endtask

  function automatic bit reads(input logic re, input logic [4:0] a, input logic [4:0] t);
    return id_valid && re && (a != 5'd0) && (a == t);
  endfunction

  task automatic test_random();
    bit e_busy, e_stall, e_start, e_issue;
    do_reset();
    m_exe_v = 0; m_exe_we = 0; m_exe_ld = 0; m_exe_lg = 0; m_exe_rd = 5'd0;
    m_rd = 5'd0; m_left = 0; m_ready = 0;
    for (int c = 0; c < 800; c++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_rs1_re   = ($urandom_range(0, 3) != 0);
      id_rs2_re   = ($urandom_range(0, 1) != 0);
      id_rd_we    = ($urandom_range(0, 3) != 0);
      id_mem_re   = ($urandom_range(0, 2) == 0);
      id_long     = ($urandom_range(0, 7) == 0);
      ext_stall   = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      long_wb_ack = ($urandom_range(0, 2) == 0);
      e_busy  = (m_left > 0) || m_ready;
      e_stall = !flush && (
                  (m_exe_v && m_exe_we && m_exe_ld &&
                   (reads(id_rs1_re, id_rs1_addr, m_exe_rd) || reads(id_rs2_re, id_rs2_addr, m_exe_rd))) ||
                  (e_busy && (reads(id_rs1_re, id_rs1_addr, m_rd) || reads(id_rs2_re, id_rs2_addr, m_rd) ||
                              (id_valid && id_rd_we && id_rd_addr == m_rd))) ||
                  (id_valid && id_long && (e_busy || (m_exe_v && m_exe_lg))));
      e_start = m_exe_v && m_exe_lg && !ext_stall && !flush && !e_busy;
      #1;
      n_checks++; if (stall !== e_stall) begin
        n_errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, e_stall); end
      n_checks++; if (long_start !== e_start) begin
        n_errors++; $display("FAIL rnd_start c=%0d: got %b expected %b", c, long_start, e_start); end
      n_checks++; if (long_busy !== e_busy || long_wb_req !== m_ready) begin
        n_errors++; $display("FAIL rnd_busy c=%0d: got busy=%b req=%b expected %b/%b",
                             c, long_busy, long_wb_req, e_busy, m_ready); end
      n_checks++; if (long_rd_addr !== m_rd) begin
        n_errors++; $display("FAIL rnd_rd c=%0d: got %0d expected %0d", c, long_rd_addr, m_rd); end
      if (e_start) begin
        m_left = LAT; m_rd = m_exe_rd;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ready = 1;
      end else if (m_ready && long_wb_ack) begin
        m_ready = 0;
      end
      e_issue = id_valid && !e_stall && !ext_stall && !flush;
      if (ext_stall) begin
        if (flush) m_exe_v = 0;
      end else if (e_issue) begin
        m_exe_v = 1; m_exe_rd = id_rd_addr; m_exe_we = id_rd_we; m_exe_ld = id_mem_re; m_exe_lg = id_long;
      end else begin
        m_exe_v = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    tick();
    test_reset();
    test_load_use();
    test_forward();
    test_long_dep();
    test_struct_flush();
    test_ext_stall();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter LONG_LAT, default 8, meaning execution cycles of the long-latency unit (divider); legal range 2..63.
REQ-002 SHALL have ports: clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: id_valid  input  1  decode stage holds an instruction.
REQ-005 SHALL have ports: id_rs1_addr / id_rs2_addr  input  `GPR_ADDR_SPACE  decode source registers.
REQ-006 SHALL have ports: id_rs1_re / id_rs2_re  input  1  source actually read.
REQ-007 SHALL have ports: id_rd_addr  input  `GPR_ADDR_SPACE  decode destination.
REQ-008 SHALL have ports: id_rd_we / id_mem_re / id_long  input  1  writes rd / is load / is long-latency op.
REQ-009 SHALL have ports: ext_stall  input  1  downstream freeze of the ID/EXE/MEM pipeline registers.
REQ-010 SHALL have ports: flush  input  1  kill instructions in ID and EXE.
REQ-011 SHALL have ports: long_wb_ack  input  1  writeback port granted to the long unit.
REQ-012 SHALL have ports: stall  output  1  hold PC and IF/ID, inject a bubble into EXE.
REQ-013 SHALL have ports: long_start  output  1  one-cycle pulse, long op launched.
REQ-014 SHALL have ports: long_busy  output  1  long unit not IDLE.
REQ-015 SHALL have ports: long_rd_addr  output  `GPR_ADDR_SPACE  destination of the in-flight long op.
REQ-016 SHALL have ports: long_wb_req  output  1  long result ready for writeback.

Function
REQ-017 SHALL keep an EXE slot {valid, rd, rd_we, is_load, is_long} and a MEM slot {valid, rd, rd_we, is_load}.
REQ-018 SHALL load id_* into the EXE slot on the edge where id_valid & !stall & !ext_stall & !flush holds; otherwise, when !ext_stall, the EXE slot SHALL become invalid (bubble).
REQ-019 SHALL, when !ext_stall, move a non-long EXE slot into the MEM slot and invalidate a prior MEM slot that is not overwritten; a long EXE slot SHALL go to the long unit and leave the MEM slot invalid.
REQ-020 SHALL freeze both slots while ext_stall=1, except that flush takes priority and invalidates the EXE slot.
REQ-021 SHALL treat a source as hazarding only when its re=1, its addr is nonzero, and id_valid=1.
REQ-022 SHALL raise a load-use stall when a hazarding source equals the EXE-slot rd and the EXE slot is valid, rd_we=1 and is_load=1; all other EXE or MEM matches are left to forwarding and SHALL NOT stall.
REQ-023 SHALL raise a long-dependency stall when a hazarding source, or id_rd_addr with id_rd_we=1 (WAW), equals long_rd_addr while long_busy=1.
REQ-024 SHALL raise a structural stall when id_long=1 and either long_busy=1 or the EXE slot holds a valid long op.
REQ-025 stall SHALL be the combinational OR of REQ-022..024, forced to 0 when flush=1.
REQ-026 The long unit FSM SHALL have the states IDLE, RUN and DONE.
REQ-027 SHALL transition IDLE->RUN when a long EXE slot advances (REQ-019); in that cycle long_start=1, long_rd_addr latches the EXE rd, and the counter loads LONG_LAT-1.
REQ-028 In RUN, the counter SHALL decrement every cycle regardless of ext_stall, and the FSM SHALL go RUN->DONE on the cycle the counter is 0, giving LONG_LAT cycles in RUN.
REQ-029 In DONE, long_wb_req SHALL be 1; the FSM SHALL go DONE->IDLE on long_wb_ack, and long_wb_ack SHALL be ignored in other states.
REQ-030 flush SHALL NOT affect an op already in RUN or DONE; a flushed long op in EXE SHALL never launch.
REQ-031 long_busy SHALL be 1 in RUN and DONE; dependent stalls SHALL release in the cycle after the ack edge.

Reset
REQ-032 On rst_n=0, both slots SHALL go invalid, the FSM SHALL go IDLE, the counter and long_rd_addr SHALL go to 0, and all outputs SHALL go to 0 immediately, including when reset is asserted mid-RUN or mid-DONE.
REQ-033 Release of rst_n SHALL take effect on the next clk edge, with no spurious long_start.

Verification
REQ-034 Load x5 issued, next ID add reads x5 -> stall=1 for exactly 1 cycle, then the add issues; the same sequence with rs=x0 and rd=x0 -> stall never asserts.
REQ-035 ALU op writing x5, next ID reads x5 in rs2 -> stall=0 throughout.
REQ-036 LONG_LAT=4, div rd=x7, dependent reads x7, ack held low 3 cycles in DONE -> long_start pulse 1 cycle, stall=1 for 4 RUN + 3 DONE + ack cycle, released the cycle after the ack edge.
REQ-037 Second div in ID while first in RUN -> stall until IDLE; div in EXE with flush=1 -> no long_start, long_busy stays 0.
REQ-038 ext_stall=1 for 3 cycles with a load in EXE and a dependent in ID -> slots frozen, stall held, RUN counter keeps counting.
REQ-039 rst_n low for 1 cycle mid-RUN -> long_busy, long_wb_req and stall are 0 immediately, and a dependent of the old long_rd issues without stall.
